regfile_rd: RTL and testbench

Integer register file with a registered, handshaked two-operand read port for the RockWave core. Decode presents rs1/rs2 addresses, and the block returns both operands one cycle later behind a valid/ready handshake. Writeback uses the single write port. The block owns the 31 architectural registers x1–x31; x0 is hard-wired to zero.

---
 rtl/regfile_rd_pkg.sv | 15 +
 rtl/regfile_rd_array.sv | 35 +++
 rtl/regfile_rd.sv | 93 +++++++++
 tb/tb_regfile_rd.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rd_pkg.sv
// Shared core constants and helpers for the RockWave integer register file read path.
package regfile_rd_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 31;
    localparam int unsigned ADDR_W = 5;

    // True when a write in this cycle targets a nonzero register named by raddr.
    function automatic logic fwd_hit(input logic              we,
                                     input logic [ADDR_W-1:0] waddr,
                                     input logic [ADDR_W-1:0] raddr);
        return we && (waddr == raddr) && (raddr != '0);
    endfunction

endpackage

// File: rtl/regfile_rd_array.sv
// Storage for x1-x31 with one write port and two combinational read ports; x0 reads as zero.
module regfile_rd_array
    import regfile_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b
);

    logic [XLEN-1:0] regs_q [1:NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0) rdata_a = regs_q[raddr_a];
        if (raddr_b != '0) rdata_b = regs_q[raddr_b];
    end

endmodule

// File: rtl/regfile_rd.sv
// Register file with a registered, valid/ready two-operand read port.
// Optional REGFILE_BYPASS_EN: write-to-read forwarding on load and on a stalled response.
module regfile_rd
    import regfile_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
);

    logic            rsp_valid_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] rd1, rd2;
    logic [XLEN-1:0] ld1, ld2;
    logic [XLEN-1:0] hold1, hold2;
    logic            req_hs, stall;

    regfile_rd_array u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (rs1_addr),
        .raddr_b (rs2_addr),
        .rdata_a (rd1),
        .rdata_b (rd2)
    );

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign req_hs    = req_valid && req_ready;
    assign stall     = rsp_valid_q && !rsp_ready;

`ifdef REGFILE_BYPASS_EN
    logic [ADDR_W-1:0] rs1_addr_q, rs2_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
        end else if (req_hs) begin
            rs1_addr_q <= rs1_addr;
            rs2_addr_q <= rs2_addr;
        end
    end

    // Held operands track writeback so a stalled response stays architecturally current.
    always_comb begin
        ld1   = fwd_hit(we, waddr, rs1_addr) ? wdata : rd1;
        ld2   = fwd_hit(we, waddr, rs2_addr) ? wdata : rd2;
        hold1 = (stall && fwd_hit(we, waddr, rs1_addr_q)) ? wdata : rs1_q;
        hold2 = (stall && fwd_hit(we, waddr, rs2_addr_q)) ? wdata : rs2_q;
    end
`else
    always_comb begin
        ld1   = rd1;
        ld2   = rd2;
        hold1 = rs1_q;
        hold2 = rs2_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else if (req_hs) begin
            rsp_valid_q <= 1'b1;
            rs1_q       <= ld1;
            rs2_q       <= ld2;
        end else begin
            if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
            rs1_q <= hold1;
            rs2_q <= hold2;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rs1_data  = rs1_q;
    assign rs2_data  = rs2_q;

endmodule

// File: tb/tb_regfile_rd.sv
// Directed self-checking bench for regfile_rd; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_rd;
    import regfile_rd_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_rd dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        req_valid = 1'b0;
        rs1_addr  = '0;
        rs2_addr  = '0;
    endtask

    logic [XLEN-1:0] exp_hazard, exp_stall;

    initial begin
`ifdef REGFILE_BYPASS_EN
        exp_hazard = 32'h1234_5678;
        exp_stall  = 32'hDEAD_BEEF;
`else
        exp_hazard = 32'h5555_5555;
        exp_stall  = 32'h0000_0001;
`endif
        idle();
        rsp_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rs1", rs1_data, 32'd0);
        check("reset_rs2", rs2_data, 32'd0);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);

        // Read after reset
        rst = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; rs1_addr = 5; rs2_addr = 0;
        tick();
        idle();
        check("rd_after_rst_valid", {31'b0, rsp_valid}, 32'd1);
        check("rd_after_rst_rs1", rs1_data, 32'd0);
        check("rd_after_rst_rs2", rs2_data, 32'd0);

        // Write x5 then read both ports
        we = 1'b1; waddr = 5; wdata = 32'hAAAA_AAAA;
        tick();
        idle();
        check("rsp_drained", {31'b0, rsp_valid}, 32'd0);
        req_valid = 1'b1; rs1_addr = 5; rs2_addr = 5;
        tick();
        idle();
        check("wr_rd_valid", {31'b0, rsp_valid}, 32'd1);
        check("wr_rd_rs1", rs1_data, 32'hAAAA_AAAA);
        check("wr_rd_rs2", rs2_data, 32'hAAAA_AAAA);

        // x0 stays zero
        we = 1'b1; waddr = 0; wdata = 32'hFFFF_FFFF;
        tick();
        idle();
        req_valid = 1'b1; rs1_addr = 0; rs2_addr = 5;
        tick();
        idle();
        check("x0_rs1", rs1_data, 32'd0);
        check("x0_rs2_x5", rs2_data, 32'hAAAA_AAAA);

        // Same-cycle write/read hazard on x7
        we = 1'b1; waddr = 7; wdata = 32'h5555_5555;
        tick();
        we = 1'b1; waddr = 7; wdata = 32'h1234_5678;
        req_valid = 1'b1; rs1_addr = 7; rs2_addr = 7;
        tick();
        idle();
        check("hazard_rs1", rs1_data, exp_hazard);
        check("hazard_rs2", rs2_data, exp_hazard);
        req_valid = 1'b1; rs1_addr = 7; rs2_addr = 0;
        tick();
        idle();
        check("post_hazard_rs1", rs1_data, 32'h1234_5678);

        // Back-to-back reads of x10..x13
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; waddr = ADDR_W'(10 + i); wdata = 32'h0100_0000 * (i + 1);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; rs1_addr = ADDR_W'(10 + i); rs2_addr = ADDR_W'(13 - i);
            tick();
            check("b2b_valid", {31'b0, rsp_valid}, 32'd1);
            check("b2b_rs1", rs1_data, 32'h0100_0000 * (i + 1));
            check("b2b_rs2", rs2_data, 32'h0100_0000 * (4 - i));
        end
        idle();
        tick();

        // Stall with writes
        we = 1'b1; waddr = 3; wdata = 32'h0000_0001;
        tick();
        idle();
        rsp_ready = 1'b0;
        req_valid = 1'b1; rs1_addr = 5; rs2_addr = 3;
        tick();
        check("stall_valid", {31'b0, rsp_valid}, 32'd1);
        check("stall_rs2_init", rs2_data, 32'h0000_0001);
        check("stall_req_ready", {31'b0, req_ready}, 32'd0);
        rs1_addr = 7; rs2_addr = 7;
        we = 1'b1; waddr = 3; wdata = 32'hDEAD_BEEF;
        tick();
        check("stall_wr_rs2", rs2_data, exp_stall);
        check("stall_wr_rs1", rs1_data, 32'hAAAA_AAAA);
        check("stall_req_ready2", {31'b0, req_ready}, 32'd0);
        we = 1'b1; waddr = 9; wdata = 32'h0000_0999;
        tick();
        check("stall_nomatch_rs1", rs1_data, 32'hAAAA_AAAA);
        check("stall_nomatch_rs2", rs2_data, exp_stall);
        check("stall_still_valid", {31'b0, rsp_valid}, 32'd1);
        idle();
        rsp_ready = 1'b1;
        #1;
        check("unstall_req_ready", {31'b0, req_ready}, 32'd1);
        tick();
        check("unstall_drained", {31'b0, rsp_valid}, 32'd0);

        // Reset mid-stall, with a write in the reset cycle
        rsp_ready = 1'b0;
        req_valid = 1'b1; rs1_addr = 5; rs2_addr = 7;
        tick();
        idle();
        check("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        we = 1'b1; waddr = 4; wdata = 32'h0000_0044;
        tick();
        rst = 1'b0;
        idle();
        check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_rs1", rs1_data, 32'd0);
        check("mid_rst_rs2", rs2_data, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            req_valid = 1'b1; rs1_addr = ADDR_W'(i); rs2_addr = ADDR_W'(32 - i);
            tick();
            check("cleared_rs1", rs1_data, 32'd0);
            check("cleared_rs2", rs2_data, 32'd0);
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
